dpram_core: RTL



---
 rtl/dpram_pkg.sv | 20 ++
 rtl/dpram_if.sv | 20 ++
 rtl/dpram_init_fsm.sv | 68 ++++++
 rtl/dpram_core.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared types and defaults for the dual-port RAM core.
//   dpram_state_e    : clear-engine states (CLEAR, READY)
//   DPRAM_ADDR_W/_DATA_W : default address / data widths
//   clr_cnt_width()  : clear-counter width, one bit wider than the address
package dpram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dpram_state_e;

    localparam int unsigned DPRAM_ADDR_W = 8;
    localparam int unsigned DPRAM_DATA_W = 32;

    // Extra bit keeps DEPTH == 2**ADDR_WIDTH from wrapping the counter early.
    function automatic int unsigned clr_cnt_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/dpram_if.sv
// One RAM access port: en/we/addr/wdata toward the memory, rdata back.
//   cpu : master side (drives the request, receives rdata)
//   mem : slave side (receives the request, drives rdata)
interface dpram_if
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DPRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH = DPRAM_DATA_W
) ();

    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport cpu (output en, output we, output addr, output wdata, input rdata);
    modport mem (input en, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/dpram_init_fsm.sv
// Post-reset clear engine: walks every word once writing zero, then parks in READY.
//   clk, rst      : clock, asynchronous active-high reset
//   o_clr_we_c    : clear write enable (combinational, high during CLEAR)
//   o_clr_addr_c  : word being cleared this cycle
//   o_init_done   : registered, high exactly while the engine is in READY
module dpram_init_fsm
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DPRAM_ADDR_W,
    parameter int unsigned DEPTH      = 32'(1) << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_clr_we_c,
    output logic [ADDR_WIDTH-1:0] o_clr_addr_c,
    output logic                  o_init_done
);

    localparam int unsigned CNT_W = clr_cnt_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);

    dpram_state_e     r_state;
    dpram_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_clr_cnt;
    logic [CNT_W-1:0] w_clr_cnt_nxt;
    logic             r_init_done;

    // State, counter and done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CLEAR;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_init_done <= (w_state_nxt == READY);
        end
    end

    // Next state and clear-port drive
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        o_clr_we_c    = 1'b0;
        o_clr_addr_c  = r_clr_cnt[ADDR_WIDTH-1:0];
        case (r_state)
            CLEAR: begin
                o_clr_we_c = 1'b1;
                if (r_clr_cnt == LAST_WORD) begin
                    w_state_nxt   = READY;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + CNT_W'(1);
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign o_init_done = r_init_done;

endmodule

// File: rtl/dpram_core.sv
// Dual-port synchronous RAM, read-first on both ports, zero-filled after reset.
//   clk, rst   : clock, asynchronous active-high reset
//   port_a/b   : dpram_if.mem access ports (en, we, addr, wdata in; rdata out)
//   init_done  : high once the post-reset clear has finished
//   collision  : one-cycle pulse when both ports write the same address
//   oob_err    : one-cycle pulse when any enabled access has addr >= DEPTH
// Optional build macro DPRAM_OUTREG_EN adds an output register on each rdata
// (read latency 2); without it read latency is 1.
module dpram_core
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DPRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH = DPRAM_DATA_W,
    parameter int unsigned DEPTH      = 32'(1) << ADDR_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    dpram_if.mem   port_a,
    dpram_if.mem   port_b,
    output logic   init_done,
    output logic   collision,
    output logic   oob_err
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_ready;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    logic                  w_a_acc, w_b_acc;
    logic                  w_a_inb, w_b_inb;
    logic                  w_a_wr, w_b_wr;
    logic                  w_same_addr;

    logic [DATA_WIDTH-1:0] r_a_rdata, r_b_rdata;
    logic                  r_collision, r_oob_err;

    dpram_init_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_init_fsm (
        .clk          (clk),
        .rst          (rst),
        .o_clr_we_c   (w_clr_we),
        .o_clr_addr_c (w_clr_addr),
        .o_init_done  (init_done)
    );

    // Port traffic is only honoured once the clear has completed
    assign w_ready     = init_done;
    assign w_a_acc     = w_ready & port_a.en;
    assign w_b_acc     = w_ready & port_b.en;
    assign w_a_inb     = (32'(port_a.addr) < DEPTH);
    assign w_b_inb     = (32'(port_b.addr) < DEPTH);
    assign w_a_wr      = w_a_acc & port_a.we & w_a_inb;
    assign w_b_wr      = w_b_acc & port_b.we & w_b_inb;
    assign w_same_addr = (port_a.addr == port_b.addr);

    // Storage: clear engine owns the array during CLEAR; port A wins a shared write
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_b_wr && !(w_a_wr && w_same_addr)) begin
                r_mem[port_b.addr] <= port_b.wdata;
            end
            if (w_a_wr) begin
                r_mem[port_a.addr] <= port_a.wdata;
            end
        end
    end

    // Read-first data capture and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_collision <= 1'b0;
            r_oob_err   <= 1'b0;
        end else begin
            if (w_a_acc) begin
                r_a_rdata <= w_a_inb ? r_mem[port_a.addr] : '0;
            end
            if (w_b_acc) begin
                r_b_rdata <= w_b_inb ? r_mem[port_b.addr] : '0;
            end
            r_collision <= w_a_acc & port_a.we & w_b_acc & port_b.we & w_same_addr;
            r_oob_err   <= (w_a_acc & ~w_a_inb) | (w_b_acc & ~w_b_inb);
        end
    end

    assign collision = r_collision;
    assign oob_err   = r_oob_err;

`ifdef DPRAM_OUTREG_EN
    logic                  r_a_en_d, r_b_en_d;
    logic [DATA_WIDTH-1:0] r_a_rdata_q, r_b_rdata_q;

    // Second rdata stage, loaded only when the previous cycle carried a request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_en_d    <= 1'b0;
            r_b_en_d    <= 1'b0;
            r_a_rdata_q <= '0;
            r_b_rdata_q <= '0;
        end else begin
            r_a_en_d <= w_a_acc;
            r_b_en_d <= w_b_acc;
            if (r_a_en_d) begin
                r_a_rdata_q <= r_a_rdata;
            end
            if (r_b_en_d) begin
                r_b_rdata_q <= r_b_rdata;
            end
        end
    end

    assign port_a.rdata = r_a_rdata_q;
    assign port_b.rdata = r_b_rdata_q;
`else
    assign port_a.rdata = r_a_rdata;
    assign port_b.rdata = r_b_rdata;
`endif

endmodule
